// File: rtl/pe_exec_unit.sv
// Vector PE execution stage: lane-wise ADD/SUB/MUL into s1_reg and a two-stage
// pipelined dot product into s2_reg, with store pulses back to fetch/decode.
module pe_exec_unit #(
    parameter int DATA_LEN      = 32,
    parameter int PE_ELEMENTS   = 4,
    parameter int PE_OPCODE_LEN = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [PE_OPCODE_LEN-1:0]               pe_opcode,
    input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]   data_a,
    input  logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]   data_b,
    output logic [PE_ELEMENTS-1:0][DATA_LEN-1:0]   pe_stage_1_output,
    output logic                                   pe_stage_1_valid,
    output logic [DATA_LEN-1:0]                    pe_stage_2_output,
    output logic                                   pe_stage_2_valid,
    output logic                                   store_result,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   illegal_op
);

    // state    | meaning
    // S_IDLE   | no program running, ops are accepted and start a program
    // S_RUN    | program executing
    // S_DRAIN1 | first cycle after STOP, ops ignored, in-flight pulses finish
    // S_DRAIN2 | second drain cycle
    // S_DONE   | done pulse; otherwise behaves exactly like S_IDLE
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2, S_DONE} state_t;

    localparam logic [PE_OPCODE_LEN-1:0] OP_NOP    = PE_OPCODE_LEN'(0);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ADD    = PE_OPCODE_LEN'(1);
    localparam logic [PE_OPCODE_LEN-1:0] OP_SUB    = PE_OPCODE_LEN'(2);
    localparam logic [PE_OPCODE_LEN-1:0] OP_MUL    = PE_OPCODE_LEN'(3);
    localparam logic [PE_OPCODE_LEN-1:0] OP_DOTP   = PE_OPCODE_LEN'(4);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ST_S1  = PE_OPCODE_LEN'(5);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ST_S2  = PE_OPCODE_LEN'(6);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ST_RES = PE_OPCODE_LEN'(7);
    localparam logic [PE_OPCODE_LEN-1:0] OP_STOP   = PE_OPCODE_LEN'(8);

    state_t state, state_next;
    logic   exec_en;
    logic   illegal;

    logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] s1_reg;
    logic [PE_ELEMENTS-1:0][DATA_LEN-1:0] prod;
    logic [DATA_LEN-1:0]                  s2_reg;
    logic [DATA_LEN-1:0]                  prod_sum;
    logic [DATA_LEN-1:0]                  s2_next;
    logic                                 dotp_pend;
    logic                                 s2_store_pend;

    assign illegal = (pe_opcode > OP_STOP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (pe_opcode == OP_STOP) begin
                    state_next = S_DONE;
                end else if (pe_opcode != OP_NOP && !illegal) begin
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (pe_opcode == OP_STOP) begin
                    state_next = S_DRAIN1;
                end
            end
            S_DRAIN1: state_next = S_DRAIN2;
            S_DRAIN2: state_next = S_DONE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        exec_en = 1'b1;
        case (state)
            S_RUN:    busy = 1'b1;
            S_DRAIN1,
            S_DRAIN2: begin
                busy    = 1'b1;
                exec_en = 1'b0;
            end
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            prod_sum = prod_sum + prod[i];
        end
    end

    // A store-S2 reads the value s2_reg takes on the same edge it is captured,
    // so a DOTP issued alongside or just before the store is always visible.
    assign s2_next = dotp_pend ? prod_sum : s2_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_reg            <= '0;
            prod              <= '0;
            s2_reg            <= '0;
            dotp_pend         <= 1'b0;
            s2_store_pend     <= 1'b0;
            pe_stage_1_output <= '0;
            pe_stage_1_valid  <= 1'b0;
            pe_stage_2_output <= '0;
            pe_stage_2_valid  <= 1'b0;
            store_result      <= 1'b0;
            illegal_op        <= 1'b0;
        end else begin
            if (exec_en) begin
                for (int i = 0; i < PE_ELEMENTS; i++) begin
                    case (pe_opcode)
                        OP_ADD:  s1_reg[i] <= data_a[i] + data_b[i];
                        OP_SUB:  s1_reg[i] <= data_a[i] - data_b[i];
                        OP_MUL:  s1_reg[i] <= data_a[i] * data_b[i];
                        OP_DOTP: prod[i]   <= data_a[i] * data_b[i];
                        default: ;
                    endcase
                end
            end
            dotp_pend     <= exec_en && (pe_opcode == OP_DOTP);
            s2_store_pend <= exec_en && (pe_opcode == OP_ST_S2);
            if (dotp_pend) begin
                s2_reg <= prod_sum;
            end

            pe_stage_1_valid <= exec_en && (pe_opcode == OP_ST_S1);
            if (exec_en && (pe_opcode == OP_ST_S1)) begin
                pe_stage_1_output <= s1_reg;
            end

            pe_stage_2_valid <= s2_store_pend;
            if (s2_store_pend) begin
                pe_stage_2_output <= s2_next;
            end

            store_result <= exec_en && (pe_opcode == OP_ST_RES);
            illegal_op   <= illegal;
        end
    end

endmodule

// File: tb/tb_pe_exec_unit.sv
// Self-checking bench for pe_exec_unit: directed scenarios plus a randomized run
// against a cycle-indexed behavioural model of the execution stage.
module tb_pe_exec_unit;
    localparam int DL = 32;
    localparam int PE = 4;
    localparam int OL = 4;
    typedef logic [PE-1:0][DL-1:0] vec_t;
    typedef struct {int at; logic [DL-1:0] val;} pend_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [OL-1:0] pe_opcode;
    vec_t          data_a, data_b, s1_out;
    logic [DL-1:0] s2_out;
    logic          v1, v2, sr, busy, done, ill;

    pe_exec_unit #(.DATA_LEN(DL), .PE_ELEMENTS(PE), .PE_OPCODE_LEN(OL)) dut (
        .clk(clk), .rstn(rstn), .pe_opcode(pe_opcode),
        .data_a(data_a), .data_b(data_b),
        .pe_stage_1_output(s1_out), .pe_stage_1_valid(v1),
        .pe_stage_2_output(s2_out), .pe_stage_2_valid(v2),
        .store_result(sr), .busy(busy), .done(done), .illegal_op(ill)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: program mode 0 idle, 1 running, 2 draining
    vec_t          m_s1;
    logic [DL-1:0] m_s2;
    int            m_mode, m_left;
    pend_t         q[$];
    vec_t          e_o1;
    logic [DL-1:0] e_o2;
    logic          e_v1, e_v2, e_sr, e_busy, e_done, e_ill;

    function automatic vec_t mkvec(input logic [DL-1:0] l0, l1, l2, l3);
        vec_t v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        return v;
    endfunction

    function automatic vec_t rndvec();
        vec_t v;
        for (int i = 0; i < PE; i++) v[i] = (($urandom & 3) == 0) ? DL'($urandom_range(0, 9)) : $urandom;
        return v;
    endfunction

    // Drive one cycle's inputs, advance the model, then wait past the edge.
    task automatic step(input int op, input vec_t a, input vec_t b, input bit rst);
        logic [DL-1:0] acc;
        pe_opcode = op[OL-1:0];
        data_a    = a;
        data_b    = b;
        rstn      = !rst;
        e_v1 = 0; e_v2 = 0; e_sr = 0; e_done = 0; e_ill = 0;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; e_o1 = '0; e_o2 = '0;
            m_mode = 0; m_left = 0; e_busy = 0;
            q.delete();
        end else begin
            e_ill = (op > 8);
            if (m_mode != 2) begin
                case (op)
                    1: for (int i = 0; i < PE; i++) m_s1[i] = a[i] + b[i];
                    2: for (int i = 0; i < PE; i++) m_s1[i] = a[i] - b[i];
                    3: for (int i = 0; i < PE; i++) m_s1[i] = a[i] * b[i];
                    4: begin
                        acc = '0;
                        for (int i = 0; i < PE; i++) acc = acc + a[i] * b[i];
                        m_s2 = acc;
                    end
                    5: begin e_v1 = 1; e_o1 = m_s1; end
                    6: q.push_back('{cyc + 2, m_s2});
                    7: e_sr = 1;
                    default: ;
                endcase
            end
            case (m_mode)
                0: begin
                    if (op == 8) e_done = 1;
                    else if (op >= 1 && op <= 7) m_mode = 1;
                end
                1: if (op == 8) begin m_mode = 2; m_left = 2; end
                default: begin
                    if (m_left == 2) m_left = 1;
                    else begin m_mode = 0; e_done = 1; end
                end
            endcase
            e_busy = (m_mode != 0);
            if (q.size() > 0 && q[0].at == cyc + 1) begin
                e_v2 = 1;
                e_o2 = q[0].val;
                void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop();
        step(0, '0, '0, 0);
    endtask

    task automatic test_reset();
        step(0, '0, '0, 1);
        step(0, '0, '0, 1);
        total += 8;
        if (v1 !== 1'b0)     begin bad++; $display("FAIL reset_v1 got=%0h exp=0", v1); end
        if (v2 !== 1'b0)     begin bad++; $display("FAIL reset_v2 got=%0h exp=0", v2); end
        if (sr !== 1'b0)     begin bad++; $display("FAIL reset_sr got=%0h exp=0", sr); end
        if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
        if (ill !== 1'b0)    begin bad++; $display("FAIL reset_ill got=%0h exp=0", ill); end
        if (s1_out !== '0)   begin bad++; $display("FAIL reset_o1 got=%0h exp=0", s1_out); end
        if (s2_out !== '0)   begin bad++; $display("FAIL reset_o2 got=%0h exp=0", s2_out); end
    endtask

    task automatic test_add();
        step(1, mkvec(1, 2, 3, 4), mkvec(10, 20, 30, 40), 0);
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_rise got=%0h exp=1", busy); end
        if (v1 !== 1'b0)   begin bad++; $display("FAIL add_v1_early got=%0h exp=0", v1); end
        step(5, rndvec(), rndvec(), 0);
        total += 3;
        if (v1 !== 1'b1) begin bad++; $display("FAIL add_v1 got=%0h exp=1", v1); end
        if (s1_out !== mkvec(11, 22, 33, 44))
            begin bad++; $display("FAIL add_out got=%h exp=%h", s1_out, mkvec(11, 22, 33, 44)); end
        if (s1_out !== e_o1) begin bad++; $display("FAIL add_model got=%h exp=%h", s1_out, e_o1); end
        nop();
        total++;
        if (v1 !== 1'b0) begin bad++; $display("FAIL add_v1_late got=%0h exp=0", v1); end
    endtask

    task automatic test_sub_mul();
        step(2, mkvec(0, 7, 7, 7), mkvec(1, 3, 3, 3), 0);
        step(5, '0, '0, 0);
        total += 2;
        if (v1 !== 1'b1) begin bad++; $display("FAIL sub_v1 got=%0h exp=1", v1); end
        if (s1_out[0] !== 32'hFFFF_FFFF)
            begin bad++; $display("FAIL sub_lane0 got=%h exp=ffffffff", s1_out[0]); end
        step(3, mkvec(0, 32'h0001_0000, 5, 6), mkvec(9, 32'h0001_0000, 5, 6), 0);
        step(5, '0, '0, 0);
        total += 3;
        if (s1_out[1] !== 32'h0) begin bad++; $display("FAIL mul_lane1 got=%h exp=0", s1_out[1]); end
        if (s1_out[3] !== 32'd36) begin bad++; $display("FAIL mul_lane3 got=%0d exp=36", s1_out[3]); end
        if (s1_out !== e_o1) begin bad++; $display("FAIL mul_model got=%h exp=%h", s1_out, e_o1); end
    endtask

    task automatic test_dotp();
        step(4, mkvec(1, 2, 3, 4), mkvec(5, 6, 7, 8), 0);
        step(6, '0, '0, 0);
        total++;
        if (v2 !== 1'b0) begin bad++; $display("FAIL dotp_v2_early got=%0h exp=0", v2); end
        nop();
        total += 2;
        if (v2 !== 1'b1) begin bad++; $display("FAIL dotp_v2 got=%0h exp=1", v2); end
        if (s2_out !== 32'd70) begin bad++; $display("FAIL dotp_70 got=%0d exp=70", s2_out); end
        nop();
        total += 2;
        if (v2 !== 1'b0) begin bad++; $display("FAIL dotp_v2_late got=%0h exp=0", v2); end
        if (s2_out !== 32'd70) begin bad++; $display("FAIL dotp_hold got=%0d exp=70", s2_out); end
        step(4, mkvec('1, '1, '1, '1), mkvec(1, 1, 1, 1), 0);
        step(6, '0, '0, 0);
        nop();
        total += 2;
        if (v2 !== 1'b1) begin bad++; $display("FAIL dotp_wrap_v2 got=%0h exp=1", v2); end
        if (s2_out !== 32'hFFFF_FFFC)
            begin bad++; $display("FAIL dotp_wrap got=%h exp=fffffffc", s2_out); end
    endtask

    task automatic test_back_to_back();
        int n_v2 = 0;
        int n_sr = 0;
        for (int k = 0; k < 13; k++) begin
            if (k < 8)       step((k % 2 == 0) ? 4 : 6, rndvec(), rndvec(), 0);
            else if (k == 8) step(7, '0, '0, 0);
            else             nop();
            total += 2;
            if (v2 !== e_v2) begin bad++; $display("FAIL b2b_v2 k=%0d got=%0h exp=%0h", k, v2, e_v2); end
            if (sr !== e_sr) begin bad++; $display("FAIL b2b_sr k=%0d got=%0h exp=%0h", k, sr, e_sr); end
            if (e_v2) begin
                total++;
                if (s2_out !== e_o2) begin bad++; $display("FAIL b2b_val k=%0d got=%h exp=%h", k, s2_out, e_o2); end
            end
            n_v2 += int'(v2);
            n_sr += int'(sr);
        end
        total += 2;
        if (n_v2 != 4) begin bad++; $display("FAIL b2b_v2_count got=%0d exp=4", n_v2); end
        if (n_sr != 1) begin bad++; $display("FAIL b2b_sr_count got=%0d exp=1", n_sr); end
    endtask

    task automatic test_stop_drain();
        vec_t saved;
        int   n_done = 0;
        step(4, rndvec(), rndvec(), 0);
        step(6, '0, '0, 0);
        step(8, '0, '0, 0);
        total += 3;
        if (v2 !== 1'b1) begin bad++; $display("FAIL drain_v2 got=%0h exp=1", v2); end
        if (s2_out !== e_o2) begin bad++; $display("FAIL drain_val got=%h exp=%h", s2_out, e_o2); end
        if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%0h exp=1", busy); end
        saved = m_s1;
        step(1, mkvec(100, 100, 100, 100), mkvec(1, 1, 1, 1), 0);
        n_done += int'(done);
        nop();
        n_done += int'(done);
        total += 2;
        if (done !== 1'b1) begin bad++; $display("FAIL drain_done got=%0h exp=1", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy_fall got=%0h exp=0", busy); end
        for (int k = 0; k < 3; k++) begin
            nop();
            n_done += int'(done);
        end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL drain_done_count got=%0d exp=1", n_done); end
        step(5, '0, '0, 0);
        total += 2;
        if (v1 !== 1'b1) begin bad++; $display("FAIL drain_s1_v1 got=%0h exp=1", v1); end
        if (s1_out !== saved) begin bad++; $display("FAIL drain_add_ignored got=%h exp=%h", s1_out, saved); end
        step(12, rndvec(), rndvec(), 0);
        total += 6;
        if (ill !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%0h exp=1", ill); end
        if (v1 !== 1'b0 || v2 !== 1'b0 || sr !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL ill_side_pulse got=%0h%0h%0h%0h exp=0000", v1, v2, sr, done); end
        if (busy !== 1'b1) begin bad++; $display("FAIL ill_busy got=%0h exp=1", busy); end
        if (s1_out !== saved) begin bad++; $display("FAIL ill_o1 got=%h exp=%h", s1_out, saved); end
        if (s2_out !== e_o2) begin bad++; $display("FAIL ill_o2 got=%h exp=%h", s2_out, e_o2); end
        nop();
        if (ill !== 1'b0) begin bad++; $display("FAIL ill_one_cycle got=%0h exp=0", ill); end
    endtask

    task automatic test_reset_inflight();
        step(4, mkvec(1, 2, 3, 4), mkvec(5, 6, 7, 8), 0);
        step(6, '0, '0, 0);
        step(0, '0, '0, 1);
        total += 5;
        if (v2 !== 1'b0)   begin bad++; $display("FAIL rst_fl_v2 got=%0h exp=0", v2); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_fl_busy got=%0h exp=0", busy); end
        if (s1_out !== '0) begin bad++; $display("FAIL rst_fl_o1 got=%h exp=0", s1_out); end
        if (s2_out !== '0) begin bad++; $display("FAIL rst_fl_o2 got=%h exp=0", s2_out); end
        if (v1 !== 1'b0 || sr !== 1'b0 || done !== 1'b0 || ill !== 1'b0)
            begin bad++; $display("FAIL rst_fl_pulses got=%0h%0h%0h%0h exp=0000", v1, sr, done, ill); end
        for (int k = 0; k < 2; k++) begin
            nop();
            total++;
            if (v2 !== 1'b0) begin bad++; $display("FAIL rst_fl_v2_after k=%0d got=%0h exp=0", k, v2); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 15), rndvec(), rndvec(), $urandom_range(0, 63) == 0);
            total += 8;
            if (v1 !== e_v1)     begin bad++; $display("FAIL rnd_v1 c=%0d got=%0h exp=%0h", cyc, v1, e_v1); end
            if (s1_out !== e_o1) begin bad++; $display("FAIL rnd_o1 c=%0d got=%h exp=%h", cyc, s1_out, e_o1); end
            if (v2 !== e_v2)     begin bad++; $display("FAIL rnd_v2 c=%0d got=%0h exp=%0h", cyc, v2, e_v2); end
            if (s2_out !== e_o2) begin bad++; $display("FAIL rnd_o2 c=%0d got=%h exp=%h", cyc, s2_out, e_o2); end
            if (sr !== e_sr)     begin bad++; $display("FAIL rnd_sr c=%0d got=%0h exp=%0h", cyc, sr, e_sr); end
            if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", cyc, busy, e_busy); end
            if (done !== e_done) begin bad++; $display("FAIL rnd_done c=%0d got=%0h exp=%0h", cyc, done, e_done); end
            if (ill !== e_ill)   begin bad++; $display("FAIL rnd_ill c=%0d got=%0h exp=%0h", cyc, ill, e_ill); end
        end
    endtask

    initial begin
        rstn = 1'b0;
        pe_opcode = '0;
        data_a = '0;
        data_b = '0;
        #2;
        test_reset();
        test_add();
        test_sub_mul();
        test_dotp();
        test_back_to_back();
        test_stop_drain();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_exec_unit.md
Name: pe_exec_unit

Overview:
- Vector processing-element execution stage, directly downstream of the PE fetch/decode stage.
- Consumes the per-cycle decoded pe_opcode and the registered operand vectors data_a/data_b.
- Stage 1: lane-wise ADD/SUB/MUL into a vector temp register. Stage 2: pipelined dot product into a scalar temp register.
- Returns results to the fetch stage through the stage-1/stage-2 valid pulses and the store_result pulse.

Parameters:
- DATA_LEN, 32, lane width in bits; all arithmetic is modulo 2^DATA_LEN.
- PE_ELEMENTS, 4, number of lanes; must be a power of 2, at least 2.
- PE_OPCODE_LEN, 4, width of pe_opcode.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- pe_opcode  in  PE_OPCODE_LEN  decoded op, one instruction per cycle:
  - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DOTP
  - 5 STORE_TEMP_S1, 6 STORE_TEMP_S2, 7 STORE_RESULT, 8 STOP
- data_a  in  PE_ELEMENTS x DATA_LEN  operand vector A; lane i = data_a[i].
- data_b  in  PE_ELEMENTS x DATA_LEN  operand vector B.
- pe_stage_1_output  out  PE_ELEMENTS x DATA_LEN  vector result.
- pe_stage_1_valid  out  1  one-cycle pulse qualifying pe_stage_1_output.
- pe_stage_2_output  out  DATA_LEN  scalar dot-product result.
- pe_stage_2_valid  out  1  one-cycle pulse qualifying pe_stage_2_output.
- store_result  out  1  one-cycle pulse requesting write-back of the assembled result.
- busy  out  1  high while a program is executing or draining.
- done  out  1  one-cycle pulse when STOP has fully drained.
- illegal_op  out  1  one-cycle pulse, asserted 1 cycle after an opcode in 9..2^PE_OPCODE_LEN-1 is seen.

Behaviour:
- Reset: all outputs 0; s1_reg, product registers and s2_reg cleared; FSM to IDLE; all pending pulses cancelled, including a DOTP or store in flight.
- Operands and opcode are sampled every clock edge; no stall input; at most one op issued per cycle.
- ADD/SUB/MUL (cycle t): s1_reg[i] <= a[i] op b[i] at end of t. Latency 1.
  - SUB result is a-b.
  - MUL keeps the low DATA_LEN bits of the product.
  - Overflow wraps silently.
- DOTP (cycle t):
  - prod[i] <= low DATA_LEN bits of a[i]*b[i] at end of t.
  - s2_reg <= sum of prod[i], truncated to DATA_LEN, at end of t+1. Latency 2.
  - Fully pipelined: one DOTP per cycle.
- STORE_TEMP_S1 at cycle t:
  - pe_stage_1_valid = 1 and pe_stage_1_output = s1_reg during cycle t+1.
  - An ADD/SUB/MUL at t-1 is visible.
- STORE_TEMP_S2 at cycle t:
  - pe_stage_2_valid = 1 during cycle t+2, with pe_stage_2_output = s2_reg as updated at end of t+1.
  - A DOTP issued at t-1 is visible.
  - Back-to-back DOTP/STORE_TEMP_S2 pairs produce back-to-back-by-2 pulses in issue order.
- STORE_RESULT at cycle t: store_result = 1 during t+1 only.
- Outputs pe_stage_1_output/pe_stage_2_output hold their last value when their valid is low.
- FSM:
  - IDLE: busy=0. Any opcode other than NOP or STOP → RUN, and that op executes.
  - RUN: busy=1. STOP at cycle t → DRAIN.
  - DRAIN: busy=1 for 2 cycles so an S2 store issued at t-1 still emits. Opcodes received in DRAIN are ignored as NOP. Exit → IDLE with done=1 for 1 cycle; busy=0 in the same cycle.
  - STOP received in IDLE: done pulses next cycle, no DRAIN.
- Illegal opcodes are executed as NOP and do not change FSM state.

Test Plan:
- ADD with a={1,2,3,4}, b={10,20,30,40} at t, STORE_TEMP_S1 at t+1 → pe_stage_1_valid only at t+2, output {11,22,33,44}; busy rises at t+1.
- SUB with a[0]=0, b[0]=1, then MUL with a[1]=b[1]=0x00010000, then STORE_TEMP_S1 → lane0=0xFFFFFFFF, lane1=0x00000000 (both ops applied to s1_reg in order; final store shows MUL result; check SUB via intermediate store).
- DOTP {1,2,3,4}·{5,6,7,8} at t, STORE_TEMP_S2 at t+1 → pe_stage_2_valid only at t+3 with 70; DOTP {0xFFFFFFFF x4}·{1,1,1,1} → 0xFFFFFFFC.
- Four alternating DOTP/STORE_TEMP_S2 pairs, then STORE_RESULT → four stage-2 pulses with correct values in order; store_result single pulse one cycle after its opcode.
- STORE_TEMP_S2 then STOP then ADD → S2 pulse still emitted, ADD ignored (s1_reg unchanged), done pulses once, busy falls same cycle; opcode 12 → illegal_op pulse, no other output change.
- rstn low one cycle after DOTP + STORE_TEMP_S2 issue → no pe_stage_2_valid pulse, all outputs 0, busy 0.
